// File: rtl/irq_pkg.sv
// Shared constants, register offsets and helpers for the interrupt controller.
package irq_pkg;
  localparam int NUM_SRC     = 32;
  localparam int NUM_GRP     = 8;
  localparam int SRC_PER_GRP = 4;

  localparam logic [3:0] OFS_PRI0 = 4'd0;
  localparam logic [3:0] OFS_PRI1 = 4'd1;
  localparam logic [3:0] OFS_ENA0 = 4'd2;
  localparam logic [3:0] OFS_ENA1 = 4'd3;
  localparam logic [3:0] OFS_ENA2 = 4'd4;
  localparam logic [3:0] OFS_ENA3 = 4'd5;
  localparam logic [3:0] OFS_ACT0 = 4'd6;
  localparam logic [3:0] OFS_ACT1 = 4'd7;
  localparam logic [3:0] OFS_ACT2 = 4'd8;
  localparam logic [3:0] OFS_ACT3 = 4'd9;
  localparam int         NUM_REGS = 10;

  typedef logic [1:0] prio_t;

  function automatic logic [2:0] grp_of(input logic [4:0] src);
    return src[4:2];
  endfunction
endpackage

// File: rtl/irq_controller_if.sv
// Peripheral bus bundle as seen by the interrupt controller.
interface irq_controller_if;
  logic        clk_ce_cpu;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;

  modport master (output clk_ce_cpu, bus_write, bus_read, bus_address_in, bus_data_in,
                  input  bus_data_out);
  modport slave  (input  clk_ce_cpu, bus_write, bus_read, bus_address_in, bus_data_in,
                  output bus_data_out);
endinterface

// File: rtl/irq_arbiter.sv
// Combinational arbiter: highest group priority wins, lowest source index breaks ties.
module irq_arbiter
  import irq_pkg::*;
(
  input  logic [NUM_SRC-1:0]     cand,
  input  logic [NUM_GRP-1:0][1:0] prio,
  output logic                   valid,
  output logic [4:0]             idx,
  output logic [1:0]             lvl
);
  logic [NUM_GRP-1:0] grp_hit;
  prio_t              max_lvl;
  logic [4:0]         idx_sel;

  generate
    for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_hit
      assign grp_hit[gi] = |cand[gi*SRC_PER_GRP +: SRC_PER_GRP];
    end
  endgenerate

  always_comb begin
    max_lvl = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      if (grp_hit[g] && (prio[g] > max_lvl)) max_lvl = prio[g];
    end
  end

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    idx_sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i] && (prio[grp_of(5'(i))] == max_lvl)) idx_sel = 5'(i);
    end
  end

  assign valid = |cand;
  assign idx   = valid ? idx_sel : 5'd0;
  assign lvl   = valid ? max_lvl : 2'd0;
endmodule

// File: rtl/irq_controller.sv
// Pending/enable/priority registers, edge detect, bus decode and registered CPU request.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [23:0] IRQ_BASE = 24'h002020
) (
  input  logic                  clk,
  input  logic                  reset,
  irq_controller_if.slave       bus,
  input  logic [NUM_SRC-1:0]    irq_in,
  input  logic [1:0]            cpu_level,
  output logic                  irq_req,
  output logic [4:0]            irq_vector,
  output logic [1:0]            irq_level
);
  logic [NUM_SRC-1:0]      irq_prev_reg;
  logic [NUM_SRC-1:0]      act_reg;
  logic [NUM_SRC-1:0]      ena_reg;
  logic [15:0]             pri_reg;
  logic [NUM_GRP-1:0][1:0] prio;
  logic [NUM_SRC-1:0]      rise;
  logic [NUM_SRC-1:0]      act_clr;
  logic [NUM_SRC-1:0]      cand;
  logic [23:0]             ofs;
  logic [3:0]              ofs4;
  logic                    hit;
  logic                    we;
  logic                    arb_valid;
  logic [4:0]              arb_idx;
  logic [1:0]              arb_lvl;
  logic [7:0]              rd_data;
  logic                    unused_bus_read;

  assign unused_bus_read = bus.bus_read;

  assign ofs  = bus.bus_address_in - IRQ_BASE;
  assign ofs4 = ofs[3:0];
  assign hit  = (ofs < 24'(NUM_REGS));
  assign we   = bus.clk_ce_cpu & bus.bus_write & hit;
  assign rise = irq_in & ~irq_prev_reg;
  assign prio = pri_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign act_clr[gi*8 +: 8] = (we && ofs4 == OFS_ACT0 + 4'(gi)) ? bus.bus_data_in : 8'h00;

      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          ena_reg[gi*8 +: 8] <= 8'h00;
        else if (we && ofs4 == OFS_ENA0 + 4'(gi))
          ena_reg[gi*8 +: 8] <= bus.bus_data_in;
      end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_pri
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          pri_reg[gi*8 +: 8] <= 8'h00;
        else if (we && ofs4 == OFS_PRI0 + 4'(gi))
          pri_reg[gi*8 +: 8] <= bus.bus_data_in;
      end
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cand
      assign cand[gi] = act_reg[gi] & ena_reg[gi] & (prio[gi/SRC_PER_GRP] > cpu_level);
    end
  endgenerate

  // A rise on the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev_reg <= '0;
      act_reg      <= '0;
    end else begin
      irq_prev_reg <= irq_in;
      act_reg      <= (act_reg & ~act_clr) | rise;
    end
  end

  irq_arbiter u_arb (
    .cand  (cand),
    .prio  (prio),
    .valid (arb_valid),
    .idx   (arb_idx),
    .lvl   (arb_lvl)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_req    <= 1'b0;
      irq_vector <= 5'd0;
      irq_level  <= 2'd0;
    end else begin
      irq_req    <= arb_valid;
      irq_vector <= arb_idx;
      irq_level  <= arb_lvl;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (hit) begin
      case (ofs4)
        OFS_PRI0: rd_data = pri_reg[7:0];
        OFS_PRI1: rd_data = pri_reg[15:8];
        OFS_ENA0: rd_data = ena_reg[7:0];
        OFS_ENA1: rd_data = ena_reg[15:8];
        OFS_ENA2: rd_data = ena_reg[23:16];
        OFS_ENA3: rd_data = ena_reg[31:24];
        OFS_ACT0: rd_data = act_reg[7:0];
        OFS_ACT1: rd_data = act_reg[15:8];
        OFS_ACT2: rd_data = act_reg[23:16];
        OFS_ACT3: rd_data = act_reg[31:24];
        default:  rd_data = 8'h00;
      endcase
    end
  end

  assign bus.bus_data_out = rd_data;
endmodule
